// File: rtl/word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Splits each accepted IN_W-bit word into IN_W/OUT_W chunks of
//               OUT_W bits. The chunks are emitted MSB-first or LSB-first, and
//               the order is chosen per word. Flow control is valid/ready on
//               both sides. A new word can load on the last beat of the
//               previous word without an idle cycle.
// Config      : WORD_SER_BSWAP_EN adds s_bswap. When s_bswap is high at
//               accept, the word is byte-reversed before chunking.
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_msb_first,
`ifdef WORD_SER_BSWAP_EN
  input  logic             s_bswap,
`endif
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_first,
  output logic             m_last
);

  localparam int N     = IN_W / OUT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // A word must split into a whole number of chunks.
  if ((IN_W % OUT_W) != 0 || N < 1) begin : g_bad_width
    $error("word_serializer: IN_W must be a non-zero multiple of OUT_W");
  end

`ifdef WORD_SER_BSWAP_EN
  if ((IN_W % 8) != 0) begin : g_bad_bswap_width
    $error("word_serializer: IN_W must be a multiple of 8 when byte swap is enabled");
  end
`endif

  logic [0:0]       state_q, state_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic             order_q, order_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0]  word_in;
  logic [OUT_W-1:0] chunk;
  logic             in_acc;
  logic             out_acc;
  logic             is_last;

  assign in_acc  = s_valid & s_ready;
  assign out_acc = m_valid & m_ready;
  assign is_last = (idx_q == LAST_IDX);

  // Word as it will be captured: optionally byte-reversed
  always_comb begin
    word_in = s_data;
`ifdef WORD_SER_BSWAP_EN
    if (s_bswap) begin
      for (int i = 0; i < IN_W / 8; i++) begin
        word_in[i*8 +: 8] = s_data[IN_W-8-i*8 +: 8];
      end
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave BUSY only when the last beat goes and no word replaces it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_acc) state_d = ST_BUSY;
      ST_BUSY: if (out_acc && is_last && !in_acc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: s_ready also opens on the final handshake, so words run back-to-back
  always_comb begin
    m_valid = (state_q == ST_BUSY);
    m_first = m_valid & (idx_q == '0);
    m_last  = m_valid & is_last;
    m_data  = m_valid ? chunk : '0;
    s_ready = (state_q == ST_IDLE) | (m_valid & m_ready & m_last);
  end

  // Held-word registers: capture on accept, step the chunk index on each output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      order_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      word_q  <= word_d;
      order_q <= order_d;
      idx_q   <= idx_d;
    end
  end

  // Next values for the held word, order flag and chunk index
  always_comb begin
    word_d  = word_q;
    order_d = order_q;
    idx_d   = idx_q;
    if (in_acc) begin
      word_d  = word_in;
      order_d = s_msb_first;
      idx_d   = '0;
    end else if (out_acc && !is_last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Chunk select: constant slices per index keep the mux free of variable shifts
  always_comb begin
    chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        chunk = order_q ? word_q[IN_W-1-k*OUT_W -: OUT_W] : word_q[k*OUT_W +: OUT_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_word_serializer
// Description : Self-checking bench for word_serializer. It uses a 32/8 instance
//               driven from a vector table plus hand-written multi-cycle
//               sequences, and an 8/8 instance for the single-chunk case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_msb_first;
  logic [31:0] s_data;
  logic        s_bswap;
  logic        m_valid, m_ready, m_first, m_last;
  logic [7:0]  m_data;

  logic        b_s_valid, b_s_ready, b_s_msb_first, b_s_bswap;
  logic [7:0]  b_s_data, b_m_data;
  logic        b_m_valid, b_m_ready, b_m_first, b_m_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  word_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_msb_first(s_msb_first),
`ifdef WORD_SER_BSWAP_EN
    .s_bswap(s_bswap),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_first(m_first), .m_last(m_last)
  );

  word_serializer #(.IN_W(8), .OUT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_msb_first(b_s_msb_first),
`ifdef WORD_SER_BSWAP_EN
    .s_bswap(b_s_bswap),
`endif
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_first(b_m_first), .m_last(b_m_last)
  );

  typedef struct {
    logic [31:0] data;
    logic        msb;
    logic [31:0] exp;   // expected beats, beat 0 in bits [31:24]
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  // One word through the 32/8 instance with m_ready held high
  task automatic run_word(input string tag, input logic [31:0] data, input logic msb,
                          input logic bswap, input logic [31:0] exp);
    @(negedge clk);
    s_valid = 1'b1; s_data = data; s_msb_first = msb; s_bswap = bswap; m_ready = 1'b1;
    check($sformatf("%s idle_s_ready", tag), {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_data = 32'hDEADBEEF; s_msb_first = ~msb; s_bswap = ~bswap;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s beat%0d valid", tag, k), {31'd0, m_valid}, 32'd1);
      check($sformatf("%s beat%0d data", tag, k), {24'd0, m_data}, {24'd0, exp[31-8*k -: 8]});
      check($sformatf("%s beat%0d first", tag, k), {31'd0, m_first}, {31'd0, k == 0});
      check($sformatf("%s beat%0d last", tag, k), {31'd0, m_last}, {31'd0, k == 3});
      check($sformatf("%s beat%0d s_ready", tag, k), {31'd0, s_ready}, {31'd0, k == 3});
      @(negedge clk);
    end
    check($sformatf("%s drained", tag), {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [5];
    logic [7:0] bw [3];

    vecs[0] = '{data: 32'hA1B2C3D4, msb: 1'b1, exp: 32'hA1B2C3D4};
    vecs[1] = '{data: 32'hA1B2C3D4, msb: 1'b0, exp: 32'hD4C3B2A1};
    vecs[2] = '{data: 32'h12345678, msb: 1'b1, exp: 32'h12345678};
    vecs[3] = '{data: 32'h12345678, msb: 1'b0, exp: 32'h78563412};
    vecs[4] = '{data: 32'h00FF00FF, msb: 1'b0, exp: 32'hFF00FF00};

    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_msb_first = 1'b0; s_bswap = 1'b0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_msb_first = 1'b0; b_s_bswap = 1'b0; b_m_ready = 1'b1;

    // Reset state
    #2;
    check("rst m_valid", {31'd0, m_valid}, 32'd0);
    check("rst s_ready", {31'd0, s_ready}, 32'd1);
    check("rst m_data",  {24'd0, m_data}, 32'd0);
    check("rst m_first", {31'd0, m_first}, 32'd0);
    check("rst m_last",  {31'd0, m_last}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven words
    for (int v = 0; v < 5; v++) begin
      run_word($sformatf("vec%0d", v), vecs[v].data, vecs[v].msb, 1'b0, vecs[v].exp);
    end

`ifdef WORD_SER_BSWAP_EN
    run_word("bswap_msb", 32'hA1B2C3D4, 1'b1, 1'b1, 32'hD4C3B2A1);
    run_word("bswap_lsb", 32'hA1B2C3D4, 1'b0, 1'b1, 32'hA1B2C3D4);
`endif

    // Backpressure: hold B2 for 5 cycles
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'hA1B2C3D4; s_msb_first = 1'b1; s_bswap = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("bp beat0", {24'd0, m_data}, 32'h000000A1);
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d data", i), {24'd0, m_data}, 32'h000000B2);
      check($sformatf("bp hold%0d valid", i), {31'd0, m_valid}, 32'd1);
      check($sformatf("bp hold%0d s_ready", i), {31'd0, s_ready}, 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    check("bp resume B2", {24'd0, m_data}, 32'h000000B2);
    @(negedge clk);
    check("bp C3", {24'd0, m_data}, 32'h000000C3);
    @(negedge clk);
    check("bp D4", {24'd0, m_data}, 32'h000000D4);
    check("bp D4 last", {31'd0, m_last}, 32'd1);
    @(negedge clk);
    check("bp drained", {31'd0, m_valid}, 32'd0);

    // Back-to-back: 8 contiguous beats 01..08
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h01020304; s_msb_first = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b beat%0d valid", k), {31'd0, m_valid}, 32'd1);
      check($sformatf("b2b beat%0d data", k), {24'd0, m_data}, k + 1);
      if (k == 0) s_data = 32'h05060708;
      if (k == 3) check("b2b s_ready on last", {31'd0, s_ready}, 32'd1);
      if (k == 4) begin
        check("b2b second first", {31'd0, m_first}, 32'd1);
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b drained", {31'd0, m_valid}, 32'd0);

    // Asynchronous reset mid-word, after B2 has been taken
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'hA1B2C3D4; s_msb_first = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    check("rstmid B2", {24'd0, m_data}, 32'h000000B2);
    @(negedge clk);
    check("rstmid C3", {24'd0, m_data}, 32'h000000C3);
    rst_n = 1'b0;
    #1;
    check("rstmid m_valid", {31'd0, m_valid}, 32'd0);
    check("rstmid m_data", {24'd0, m_data}, 32'd0);
    check("rstmid m_first", {31'd0, m_first}, 32'd0);
    check("rstmid m_last", {31'd0, m_last}, 32'd0);
    check("rstmid s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d m_valid", i), {31'd0, m_valid}, 32'd0);
      check($sformatf("post_rst%0d s_ready", i), {31'd0, s_ready}, 32'd1);
    end
    run_word("post_rst word", 32'hCAFEF00D, 1'b0, 1'b0, 32'h0DF0FECA);

    // Single-chunk instance: every beat is both first and last
    bw[0] = 8'h5A; bw[1] = 8'hC3; bw[2] = 8'h0F;
    @(negedge clk);
    b_s_valid = 1'b1; b_s_data = bw[0]; b_m_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("n1 beat%0d valid", i), {31'd0, b_m_valid}, 32'd1);
      check($sformatf("n1 beat%0d data", i), {24'd0, b_m_data}, {24'd0, bw[i]});
      check($sformatf("n1 beat%0d first", i), {31'd0, b_m_first}, 32'd1);
      check($sformatf("n1 beat%0d last", i), {31'd0, b_m_last}, 32'd1);
      check($sformatf("n1 beat%0d s_ready", i), {31'd0, b_s_ready}, 32'd1);
      if (i < 2) b_s_data = bw[i + 1];
      else b_s_valid = 1'b0;
      @(negedge clk);
    end
    check("n1 drained", {31'd0, b_m_valid}, 32'd0);
    check("n1 drained data", {24'd0, b_m_data}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
